// File: rtl/dfft_deser.sv
// dfft_deser -- deserializer for a toggle-encoded DFFT output stream.
//
// Each transition on q_in is one pulse (logic 1). On every bit_en cycle the
// line is compared against its previous sampled level, the decoded bit is
// shifted into a word LSB-first, and each completed WIDTH-bit word is pushed
// into a small output FIFO read through a valid/ready port.
//
// Parameters
//   WIDTH  bits per output word (2..32)
//   DEPTH  output FIFO entries (power of 2, 2..16)
// Ports
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset
//   q_in      toggle-encoded DFFT output
//   bit_en    bit-slot sample strobe (one DFFT clock period)
//   flush     synchronous clear of partial word, FIFO and overflow
//   m_data    head word of the FIFO (0 when empty)
//   m_valid   FIFO non-empty
//   m_ready   consumer accepts m_data when m_valid=1
//   level     current FIFO occupancy
//   overflow  sticky: a completed word was dropped because the FIFO was full
//   m_parity  XOR of m_data, only when DFFT_DESER_PARITY_EN is defined
//
// Build option: define DFFT_DESER_PARITY_EN to add m_parity and its storage.
//
// state | meaning
// IDLE  | bit_cnt=0, no partial word held
// ACC   | accumulating bits 1..WIDTH-1 of a word
module dfft_deser #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     q_in,
   input  logic                     bit_en,
   input  logic                     flush,
   output logic [WIDTH-1:0]         m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
`ifdef DFFT_DESER_PARITY_EN
   ,
   output logic                     m_parity
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, ACC} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
   logic             q_prev;
   logic [WIDTH-2:0] shreg;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;

   logic             bit_dec;
   logic             last_bit;
   logic [WIDTH-1:0] word_done;
   logic             full;
   logic             push;
   logic             pop;
   logic             drop;

   assign bit_dec   = q_in ^ q_prev;
   assign last_bit  = bit_en && (state == ACC) && (bit_cnt == CW'(WIDTH - 1));
   // shreg holds the bits already received, oldest at bit 0
   assign word_done = {bit_dec, shreg};
   assign full      = (level == (AW + 1)'(DEPTH));
   assign pop       = !flush && m_valid && m_ready;
   // a pop in the same cycle frees the slot, so a full FIFO can still accept
   assign push      = !flush && last_bit && (!full || m_valid && m_ready);
   assign drop      = !flush && last_bit && full && !(m_valid && m_ready);

   assign m_valid   = (level != '0);
   assign m_data    = m_valid ? mem[rd_ptr] : '0;

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      if (flush) begin
         state_nxt   = IDLE;
         bit_cnt_nxt = '0;
      end else if (bit_en) begin
         case (state)
            IDLE: begin
               state_nxt   = ACC;
               bit_cnt_nxt = CW'(1);
            end
            ACC: begin
               if (last_bit) begin
                  state_nxt   = IDLE;
                  bit_cnt_nxt = '0;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
            default: begin
               state_nxt   = IDLE;
               bit_cnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         q_prev  <= 1'b0;
         shreg   <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
         // q_prev follows the line even during flush to keep toggle tracking aligned
         if (bit_en)
            q_prev <= q_in;
         if (flush)
            shreg <= '0;
         else if (bit_en)
            shreg <= word_done[WIDTH-1:1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (drop)
            overflow <= 1'b1;
      end
   end

   // storage needs no reset: m_data is masked while the FIFO is empty
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= word_done;
   end

`ifdef DFFT_DESER_PARITY_EN
   logic par_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (push)
         par_mem[wr_ptr] <= ^word_done;
   end

   assign m_parity = m_valid ? par_mem[rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_dfft_deser.sv
// Testbench for dfft_deser (WIDTH=8, DEPTH=4). Directed scenarios plus a
// randomized run scored against a queue model of the word stream.
module tb_dfft_deser;

   logic       clk;
   logic       rst_n;
   logic       q_in;
   logic       bit_en;
   logic       flush;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [2:0] level;
   logic       overflow;
`ifdef DFFT_DESER_PARITY_EN
   logic       m_parity;
`endif

   int checks = 0;
   int failures = 0;
   logic line = 1'b0;   // current DFFT line level driven on q_in

   dfft_deser #(.WIDTH(8), .DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .q_in     (q_in),
      .bit_en   (bit_en),
      .flush    (flush),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .level    (level),
      .overflow (overflow)
`ifdef DFFT_DESER_PARITY_EN
      ,
      .m_parity (m_parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // one bit slot: a 1 is sent as a line transition
   task automatic slot(input logic b);
      if (b) line = ~line;
      q_in   = line;
      bit_en = 1'b1;
      @(posedge clk); #1;
      bit_en = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) slot(w[i]);
   endtask

   task automatic idle_cycle();
      q_in   = line;
      bit_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; q_in = 1'b0; bit_en = 1'b0; flush = 1'b0; m_ready = 1'b0;
      line = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", m_valid); end
      checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", m_data); end
      checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d want=0", level); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", overflow); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_decode();
      logic [7:0] w;
      w = 8'h85;
      m_ready = 1'b0;
      for (int i = 0; i < 7; i++) slot(w[i]);
      line = ~line; q_in = line; bit_en = 1'b1;
      #1;
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL decode_valid_early got=%b want=0", m_valid); end
      @(posedge clk); #1;
      bit_en = 1'b0;
      checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL decode_valid_latency got=%b want=1", m_valid); end
      checks++; if (m_data !== 8'h85) begin failures++; $display("FAIL decode_data got=%h want=85", m_data); end
      checks++; if (level !== 3'd1) begin failures++; $display("FAIL decode_level got=%0d want=1", level); end
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL decode_pop_valid got=%b want=0", m_valid); end
   endtask

   task automatic test_gaps();
      logic [7:0] w;
      w = 8'h66;
      // bit 0: two toggles between samples -> 0
      line = ~line; idle_cycle();
      line = ~line; idle_cycle();
      slot(1'b0);
      // bit 1: one toggle while bit_en=0 -> 1 at the next slot
      line = ~line; idle_cycle();
      idle_cycle();
      slot(1'b0);
      for (int i = 2; i < 8; i++) slot(w[i]);
      checks++; if (m_data !== 8'h66) begin failures++; $display("FAIL gaps_data got=%h want=66", m_data); end
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL gaps_pop_valid got=%b want=0", m_valid); end
   endtask

   task automatic test_overflow();
      logic [7:0] w [5];
      m_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         w[k] = 8'($urandom);
         send_word(w[k]);
      end
      checks++; if (level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d want=4", level); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", overflow); end
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++; if (m_data !== w[k]) begin failures++; $display("FAIL ovf_order[%0d] got=%h want=%h", k, m_data, w[k]); end
         @(posedge clk); #1;
      end
      m_ready = 1'b0;
      checks++; if (level !== 3'd0) begin failures++; $display("FAIL ovf_drained got=%0d want=0", level); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
   endtask

   task automatic test_flush();
      logic [7:0] wa, wb, wc;
      wa = 8'($urandom); wb = 8'($urandom); wc = 8'($urandom) | 8'h01;
      m_ready = 1'b0;
      send_word(wa);
      for (int i = 0; i < 3; i++) slot(wb[i]);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++; if (level !== 3'd0) begin failures++; $display("FAIL flush_level got=%0d want=0", level); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b want=0", overflow); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b want=0", m_valid); end
      send_word(wc);
      checks++; if (level !== 3'd1) begin failures++; $display("FAIL flush_next_level got=%0d want=1", level); end
      checks++; if (m_data !== wc) begin failures++; $display("FAIL flush_next_data got=%h want=%h", m_data, wc); end
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
   endtask

   task automatic test_full_push_pop();
      logic [7:0] w [5];
      m_ready = 1'b0;
      for (int k = 0; k < 5; k++) w[k] = 8'($urandom);
      for (int k = 0; k < 4; k++) send_word(w[k]);
      checks++; if (level !== 3'd4) begin failures++; $display("FAIL fpp_fill got=%0d want=4", level); end
      for (int i = 0; i < 7; i++) slot(w[4][i]);
      m_ready = 1'b1;
      slot(w[4][7]);
      m_ready = 1'b0;
      checks++; if (level !== 3'd4) begin failures++; $display("FAIL fpp_level got=%0d want=4", level); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf got=%b want=0", overflow); end
      m_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         checks++; if (m_data !== w[k]) begin failures++; $display("FAIL fpp_order[%0d] got=%h want=%h", k, m_data, w[k]); end
         @(posedge clk); #1;
      end
      m_ready = 1'b0;
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL fpp_empty got=%b want=0", m_valid); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] wa, wb, wc;
      wa = 8'($urandom) | 8'h80; wb = 8'($urandom); wc = 8'($urandom);
      m_ready = 1'b0;
      send_word(wa);
      for (int i = 0; i < 3; i++) slot(wb[i]);
      rst_n = 1'b0;
      #1;
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b want=0", m_valid); end
      checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h want=00", m_data); end
      checks++; if (level !== 3'd0) begin failures++; $display("FAIL rstmid_level got=%0d want=0", level); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rstmid_ovf got=%b want=0", overflow); end
      line = 1'b0; q_in = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_word(wc);
      checks++; if (m_data !== wc) begin failures++; $display("FAIL rstmid_next got=%h want=%h", m_data, wc); end
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
   endtask

`ifdef DFFT_DESER_PARITY_EN
   task automatic test_parity();
      m_ready = 1'b0;
      send_word(8'h85);
      checks++; if (m_parity !== 1'b1) begin failures++; $display("FAIL parity_85 got=%b want=1", m_parity); end
      m_ready = 1'b1; @(posedge clk); #1; m_ready = 1'b0;
      send_word(8'h03);
      checks++; if (m_parity !== 1'b0) begin failures++; $display("FAIL parity_03 got=%b want=0", m_parity); end
      m_ready = 1'b1; @(posedge clk); #1; m_ready = 1'b0;
   endtask
`endif

   // Random words with random slot gaps, double toggles on 0 bits and random
   // backpressure; the model is a bounded queue of whole words.
   task automatic test_random();
      logic [7:0] exp_q [$];
      logic       exp_ovf;
      logic [7:0] word;
      int         gap;
      logic       be;
      logic       do_pop;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      exp_ovf = 1'b0;
      for (int w = 0; w < 40; w++) begin
         word = 8'($urandom);
         for (int b = 0; b < 8; b++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g <= gap; g++) begin
               be = (g == gap);
               if (word[b] && g == 0) line = ~line;
               if (!word[b] && gap == 2 && g < 2) line = ~line;
               q_in    = line;
               bit_en  = be;
               m_ready = 1'($urandom_range(0, 1));
               checks++; if (m_valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL rnd_valid w=%0d b=%0d got=%b want=%b", w, b, m_valid, exp_q.size() != 0); end
               checks++; if (level !== 3'(exp_q.size())) begin failures++; $display("FAIL rnd_level w=%0d b=%0d got=%0d want=%0d", w, b, level, exp_q.size()); end
               checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL rnd_ovf w=%0d b=%0d got=%b want=%b", w, b, overflow, exp_ovf); end
               if (exp_q.size() != 0) begin
                  checks++; if (m_data !== exp_q[0]) begin failures++; $display("FAIL rnd_data w=%0d b=%0d got=%h want=%h", w, b, m_data, exp_q[0]); end
               end
               do_pop = m_ready && (exp_q.size() != 0);
               if (do_pop) void'(exp_q.pop_front());
               if (be && b == 7) begin
                  if (exp_q.size() < 4) exp_q.push_back(word);
                  else exp_ovf = 1'b1;
               end
               @(posedge clk); #1;
            end
         end
      end
      bit_en = 1'b0;
      m_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_decode();
      test_gaps();
      test_overflow();
      test_flush();
      test_full_push_pop();
      test_reset_mid();
`ifdef DFFT_DESER_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dfft_deser.md
DFFT_DESER -- requirements
Module: dfft_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per output word (2..32).
REQ-002 SHALL have parameter DEPTH, default 4, output FIFO entries (power of 2, 2..16).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port q_in, input, 1, toggle-encoded DFFT output: each transition is one pulse.
REQ-006 SHALL have port bit_en, input, 1, marks a bit-slot sample cycle, i.e. one DFFT clock period.
REQ-007 SHALL have port flush, input, 1, synchronous clear of the partial word and FIFO.
REQ-008 SHALL have port m_data, output, WIDTH, head word of the FIFO.
REQ-009 SHALL have port m_valid, output, 1, FIFO non-empty.
REQ-010 SHALL have port m_ready, input, 1, consumer accepts m_data when m_valid=1.
REQ-011 SHALL have port level, output, clog2(DEPTH)+1, current FIFO occupancy.
REQ-012 SHALL have port overflow, output, 1, sticky flag set when a completed word is dropped.

Function
REQ-013 SHALL hold q_prev (reset 0, matching the DFFT output reset level) and, on each bit_en=1 cycle, decode bit = q_in XOR q_prev, then load q_prev <= q_in.
REQ-014 SHALL ignore q_in when bit_en=0; a toggle occurring then SHALL be decoded at the next bit_en=1 cycle; two toggles between samples SHALL decode as 0.
REQ-015 SHALL run FSM IDLE (bit_cnt=0, no partial word) -> ACC on the first bit_en, ACC -> IDLE on the bit_en cycle that supplies bit WIDTH-1.
REQ-016 SHALL shift bits LSB-first: the first decoded bit of a word is m_data[0].
REQ-017 SHALL push the completed word into the FIFO on the clock edge that samples its last bit; m_valid SHALL rise the following cycle (latency 1 cycle after the last bit).
REQ-018 SHALL pop on m_valid & m_ready; m_data SHALL present the next entry the following cycle.
REQ-019 SHALL, when the FIFO is full and a word completes with no pop in that cycle, drop the word, set overflow, and still return to IDLE.
REQ-020 SHALL, when the FIFO is full and a push and a pop coincide, accept both; level SHALL be unchanged.
REQ-021 SHALL wrap the FIFO read/write pointers modulo DEPTH with no bubble.
REQ-022 SHALL, on flush=1, empty the FIFO, clear bit_cnt and the partial word, clear overflow, and enter IDLE; q_prev SHALL still update if bit_en=1, so toggle tracking stays aligned.
REQ-023 SHALL give flush priority over push and pop in the same cycle.

Reset
REQ-024 SHALL, while rst_n=0, force q_prev=0, bit_cnt=0, FSM=IDLE, FIFO empty, m_valid=0, m_data=0, level=0 and overflow=0.
REQ-025 SHALL discard any partial word and FIFO contents when reset asserts mid-operation; the first bit_en after release starts a new word.

Configuration
REQ-026 SHALL, with DFFT_DESER_PARITY_EN defined, add output m_parity (1 bit, XOR of m_data), stored per FIFO entry, reset to 0.
REQ-027 SHALL, without DFFT_DESER_PARITY_EN, omit the m_parity port and its storage; all other behaviour is identical.

Verification
REQ-028 SHALL test decode: WIDTH=8, q_in toggles on bit slots 0, 2, 7 (8 consecutive bit_en) -> m_data=8'h85, m_valid rises 1 cycle after slot 7.
REQ-029 SHALL test gaps and double toggles: q_in toggles twice between two bit_en cycles -> decoded bit 0; a single toggle during bit_en=0 -> bit 1 at the next slot.
REQ-030 SHALL test overflow: m_ready=0, DEPTH=4, 5 words sent -> level=4, overflow=1, first 4 words are retained in order after m_ready=1.
REQ-031 SHALL test full with coincident push and pop: level stays 4, no overflow, word order preserved.
REQ-032 SHALL test flush and reset: after 3 bits of a word, flush -> level=0, overflow=0, next 8 bits form a clean word; rst_n low mid-word -> all outputs 0.
REQ-033 SHALL test parity with DFFT_DESER_PARITY_EN: word 8'h85 -> m_parity=1; word 8'h03 -> m_parity=0.
